// File: rtl/wb_pkg.sv
// Shared types for the writeback arbiter: routing address, port FSM states,
// round-robin grant encoding and the queued result entry.
package wb_pkg;

   localparam logic [3:0] PC_ADDR  = 4'd15;
   localparam int         ENTRY_DW = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2
   } port_state_t;

   typedef enum logic {
      GNT_ALU = 1'b0,
      GNT_MEM = 1'b1
   } grant_t;

   // Default-width entry; the top re-declares the same layout at its own DW.
   typedef struct packed {
      logic [3:0]          dest;
      logic [ENTRY_DW-1:0] data;
   } entry_t;

   // A grant is only ever offered outside SETUP, so SETUP always advances.
   function automatic port_state_t port_next(input port_state_t cur, input logic gnt);
      port_state_t nxt;
      if (cur == SETUP)
         nxt = STROBE;
      else if (gnt)
         nxt = SETUP;
      else
         nxt = IDLE;
      return nxt;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-source result queue: head is combinational, and every slot is exposed
// oldest-first with a valid mask so the top can search pending writes.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int  DEPTH = 2,
   parameter type T     = entry_t
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  T                 push_data,
   input  logic             pop,
   output T                 head,
   output logic             full,
   output logic             empty,
   output T                 ents [DEPTH],
   output logic [DEPTH-1:0] ents_vld
);

   localparam int AW = $clog2(DEPTH);

   T              mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   count;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   // Slot i is the i-th oldest entry; pointers wrap because DEPTH is a power of two.
   for (genvar i = 0; i < DEPTH; i++) begin : g_ent
      assign ents[i]     = mem[rd_ptr + AW'(i)];
      assign ents_vld[i] = ((AW+1)'(i) < count);
   end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: two result queues feeding the GPR and PC write ports of the
// register file, each write issued as SETUP then a one-cycle STROBE.
// Optional WB_BYPASS_EN adds a combinational lookup over all pending writes.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          alu_valid,
   output logic          alu_ready,
   input  logic [3:0]    alu_dest,
   input  logic [DW-1:0] alu_data,
   input  logic          mem_valid,
   output logic          mem_ready,
   input  logic [3:0]    mem_dest,
   input  logic [DW-1:0] mem_data,
   output logic          write,
   output logic [3:0]    dest_add,
   output logic [DW-1:0] data_write,
   output logic          write_pc,
   output logic [DW-1:0] pc_next
`ifdef WB_BYPASS_EN
   ,
   input  logic [3:0]    lkp_add,
   output logic          lkp_hit,
   output logic [DW-1:0] lkp_data
`endif
);

   typedef struct packed {
      logic [3:0]    dest;
      logic [DW-1:0] data;
   } ent_t;

   ent_t             alu_head, mem_head;
   ent_t             alu_ents [DEPTH];
   ent_t             mem_ents [DEPTH];
   logic [DEPTH-1:0] alu_vld, mem_vld;
   logic             alu_full, alu_empty, mem_full, mem_empty;
   logic             alu_pop, mem_pop;

   port_state_t      gpr_st, pc_st;
   grant_t           last_grant;

   assign alu_ready = !alu_full && !reset;
   assign mem_ready = !mem_full && !reset;

   wb_fifo #(.DEPTH(DEPTH), .T(ent_t)) u_alu_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (alu_valid && alu_ready),
      .push_data ({alu_dest, alu_data}),
      .pop       (alu_pop),
      .head      (alu_head),
      .full      (alu_full),
      .empty     (alu_empty),
      .ents      (alu_ents),
      .ents_vld  (alu_vld)
   );

   wb_fifo #(.DEPTH(DEPTH), .T(ent_t)) u_mem_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (mem_valid && mem_ready),
      .push_data ({mem_dest, mem_data}),
      .pop       (mem_pop),
      .head      (mem_head),
      .full      (mem_full),
      .empty     (mem_empty),
      .ents      (mem_ents),
      .ents_vld  (mem_vld)
   );

   // ---- Arbitration: each head requests the port its dest routes to ----
   logic alu_gpr_req, alu_pc_req, mem_gpr_req, mem_pc_req;
   logic gpr_open, pc_open, gpr_tie, pc_tie;
   logic gpr_alu, gpr_mem, pc_alu, pc_mem;

   assign alu_gpr_req = !alu_empty && (alu_head.dest != PC_ADDR);
   assign alu_pc_req  = !alu_empty && (alu_head.dest == PC_ADDR);
   assign mem_gpr_req = !mem_empty && (mem_head.dest != PC_ADDR);
   assign mem_pc_req  = !mem_empty && (mem_head.dest == PC_ADDR);

   assign gpr_open = (gpr_st != SETUP);
   assign pc_open  = (pc_st != SETUP);
   assign gpr_tie  = alu_gpr_req && mem_gpr_req;
   assign pc_tie   = alu_pc_req && mem_pc_req;

   // On a tie the source that did not win the previous tie goes first.
   assign gpr_alu = gpr_open && alu_gpr_req && (!gpr_tie || last_grant == GNT_MEM);
   assign gpr_mem = gpr_open && mem_gpr_req && (!gpr_tie || last_grant == GNT_ALU);
   assign pc_alu  = pc_open && alu_pc_req && (!pc_tie || last_grant == GNT_MEM);
   assign pc_mem  = pc_open && mem_pc_req && (!pc_tie || last_grant == GNT_ALU);

   assign alu_pop = gpr_alu || pc_alu;
   assign mem_pop = gpr_mem || pc_mem;

   // Only contested grants move the round-robin pointer.
   always_ff @(posedge clk) begin
      if (reset)
         last_grant <= GNT_ALU;
      else if (gpr_open && gpr_tie)
         last_grant <= gpr_alu ? GNT_ALU : GNT_MEM;
      else if (pc_open && pc_tie)
         last_grant <= pc_alu ? GNT_ALU : GNT_MEM;
   end

   // ---- Port FSMs: address/data load only on entry to SETUP ----
   always_ff @(posedge clk) begin
      if (reset) begin
         gpr_st     <= IDLE;
         dest_add   <= '0;
         data_write <= '0;
      end else begin
         gpr_st <= port_next(gpr_st, gpr_alu || gpr_mem);
         if (gpr_alu)
            {dest_add, data_write} <= alu_head;
         else if (gpr_mem)
            {dest_add, data_write} <= mem_head;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_st   <= IDLE;
         pc_next <= '0;
      end else begin
         pc_st <= port_next(pc_st, pc_alu || pc_mem);
         if (pc_alu)
            pc_next <= alu_head.data;
         else if (pc_mem)
            pc_next <= mem_head.data;
      end
   end

   assign write    = (gpr_st == STROBE);
   assign write_pc = (pc_st == STROBE);

`ifdef WB_BYPASS_EN
   // Scan lowest priority first so later matches override: in-flight,
   // then ALU oldest..youngest, then MEM oldest..youngest.
   always_comb begin
      lkp_hit  = 1'b0;
      lkp_data = '0;
      if (gpr_st != IDLE && dest_add == lkp_add) begin
         lkp_hit  = 1'b1;
         lkp_data = data_write;
      end
      if (pc_st != IDLE && lkp_add == PC_ADDR) begin
         lkp_hit  = 1'b1;
         lkp_data = pc_next;
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (alu_vld[i] && alu_ents[i].dest == lkp_add) begin
            lkp_hit  = 1'b1;
            lkp_data = alu_ents[i].data;
         end
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (mem_vld[i] && mem_ents[i].dest == lkp_add) begin
            lkp_hit  = 1'b1;
            lkp_data = mem_ents[i].data;
         end
      end
   end
`else
   logic unused_bypass;
   always_comb begin
      unused_bypass = ^{alu_vld, mem_vld};
      for (int i = 0; i < DEPTH; i++)
         unused_bypass = unused_bypass ^ (^alu_ents[i]) ^ (^mem_ents[i]);
   end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: vector table, hand-written corner sequences and a
// randomized run scored against an in-order acceptance log.
module tb_wb_arbiter;

   localparam logic [3:0] PC = 4'd15;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        alu_valid = 1'b0, mem_valid = 1'b0;
   logic        alu_ready, mem_ready;
   logic [3:0]  alu_dest = '0, mem_dest = '0;
   logic [31:0] alu_data = '0, mem_data = '0;
   logic        write, write_pc;
   logic [3:0]  dest_add;
   logic [31:0] data_write, pc_next;
`ifdef WB_BYPASS_EN
   logic [3:0]  lkp_add = '0;
   logic        lkp_hit;
   logic [31:0] lkp_data;
`endif

   wb_arbiter #(.DEPTH(2), .DW(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .alu_valid  (alu_valid),
      .alu_ready  (alu_ready),
      .alu_dest   (alu_dest),
      .alu_data   (alu_data),
      .mem_valid  (mem_valid),
      .mem_ready  (mem_ready),
      .mem_dest   (mem_dest),
      .mem_data   (mem_data),
      .write      (write),
      .dest_add   (dest_add),
      .data_write (data_write),
      .write_pc   (write_pc),
      .pc_next    (pc_next)
`ifdef WB_BYPASS_EN
      ,
      .lkp_add    (lkp_add),
      .lkp_hit    (lkp_hit),
      .lkp_data   (lkp_data)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [69:0] outs();
      return {write, write_pc, dest_add, data_write, pc_next};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drop_inputs();
      alu_valid = 1'b0;
      mem_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drop_inputs();
      tick();
      tick();
      reset = 1'b0;
   endtask

   // ---- Monitor: logs acceptances and strobes, checks strobe shape ----
   typedef struct { logic [3:0] dest; logic [31:0] data; } ent_t;
   typedef struct { logic pc; logic [3:0] dest; logic [31:0] data; int cyc; } wr_t;

   ent_t acc_alu[$];
   ent_t acc_mem[$];
   wr_t  st_log[$];
   int   cyc = 0;
   logic        pw = 1'b0, ppw = 1'b0;
   logic [3:0]  pdest = '0;
   logic [31:0] pdata = '0, ppc = '0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (write === 1'b1) begin
         chk("gpr_strobe_shape", {pw, pdest, pdata}, {1'b0, dest_add, data_write});
         st_log.push_back('{1'b0, dest_add, data_write, cyc});
      end
      if (write_pc === 1'b1) begin
         chk("pc_strobe_shape", {ppw, ppc}, {1'b0, pc_next});
         st_log.push_back('{1'b1, PC, pc_next, cyc});
      end
      if (!reset && alu_valid && alu_ready === 1'b1) acc_alu.push_back('{alu_dest, alu_data});
      if (!reset && mem_valid && mem_ready === 1'b1) acc_mem.push_back('{mem_dest, mem_data});
      pw    = write;
      ppw   = write_pc;
      pdest = dest_add;
      pdata = data_write;
      ppc   = pc_next;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      logic av; logic [3:0] ad; logic [31:0] adat;
      logic mv; logic [3:0] md; logic [31:0] mdat;
      logic [3:0] e_dest; logic [31:0] e_data; logic [31:0] e_pc;
      logic e_w; logic e_wp;
   } vec_t;

   vec_t vecs[5];

   initial begin
      vecs[0] = '{1'b1, 4'd3,  32'hCAFE0001, 1'b0, 4'd0,  32'h0,   4'd3, 32'hCAFE0001, 32'h0,   1'b1, 1'b0};
      vecs[1] = '{1'b1, 4'd15, 32'h100,      1'b1, 4'd2,  32'h7,   4'd2, 32'h7,        32'h100, 1'b1, 1'b1};
      vecs[2] = '{1'b1, 4'd6,  32'h22,       1'b1, 4'd5,  32'h11,  4'd5, 32'h11,       32'h0,   1'b1, 1'b0};
      vecs[3] = '{1'b0, 4'd0,  32'h0,        1'b1, 4'd15, 32'hABC, 4'd0, 32'h0,        32'hABC, 1'b0, 1'b1};
      vecs[4] = '{1'b1, 4'd0,  32'hFFFFFFFF, 1'b0, 4'd1,  32'h0,   4'd0, 32'hFFFFFFFF, 32'h0,   1'b1, 1'b0};

      // Reset state
      reset = 1'b1;
      tick();
      tick();
      chk("reset_outs", outs(), '0);
      chk("reset_ready", {alu_ready, mem_ready}, 2'b00);
      reset = 1'b0;
      #1;
      chk("ready_after_reset", {alu_ready, mem_ready}, 2'b11);

      // Vector table: one transfer cycle, then SETUP, STROBE, idle
      for (int v = 0; v < 5; v++) begin
         do_reset();
         alu_valid = vecs[v].av; alu_dest = vecs[v].ad; alu_data = vecs[v].adat;
         mem_valid = vecs[v].mv; mem_dest = vecs[v].md; mem_data = vecs[v].mdat;
         tick();
         drop_inputs();
         tick();
         chk($sformatf("vec%0d_setup", v), outs(),
             {1'b0, 1'b0, vecs[v].e_dest, vecs[v].e_data, vecs[v].e_pc});
         tick();
         chk($sformatf("vec%0d_strobe", v), outs(),
             {vecs[v].e_w, vecs[v].e_wp, vecs[v].e_dest, vecs[v].e_data, vecs[v].e_pc});
         tick();
         chk($sformatf("vec%0d_after", v), {write, write_pc}, 2'b00);
      end

      // Round-robin: MEM wins first tie, ALU wins the next tie
      do_reset();
      alu_valid = 1'b1; alu_dest = 4'd6; alu_data = 32'h22;
      mem_valid = 1'b1; mem_dest = 4'd5; mem_data = 32'h11;
      tick();
      drop_inputs();
      tick();
      tick();
      chk("tie1_first", {write, dest_add, data_write}, {1'b1, 4'd5, 32'h11});
      tick();
      chk("tie1_gap", write, 1'b0);
      tick();
      chk("tie1_second", {write, dest_add, data_write}, {1'b1, 4'd6, 32'h22});
      alu_valid = 1'b1; alu_dest = 4'd9; alu_data = 32'h44;
      mem_valid = 1'b1; mem_dest = 4'd8; mem_data = 32'h33;
      tick();
      drop_inputs();
      tick();
      tick();
      chk("tie2_alu_first", {write, dest_add, data_write}, {1'b1, 4'd9, 32'h44});
      tick();
      tick();
      chk("tie2_mem_second", {write, dest_add, data_write}, {1'b1, 4'd8, 32'h33});

      // Continuous ALU stream, DEPTH=2: acceptance at edges 0,1,2,4,6,8
      begin
         int idx;
         int nlow;
         logic acc;
         do_reset();
         st_log.delete();
         idx  = 0;
         nlow = 0;
         for (int c = 0; c < 40 && idx < 6; c++) begin
            alu_valid = 1'b1;
            alu_dest  = 4'(idx + 1);
            alu_data  = 32'h50 + 32'(idx);
            @(negedge clk);
            acc = alu_ready;
            if (!alu_ready) nlow++;
            tick();
            if (acc) idx++;
         end
         drop_inputs();
         repeat (10) tick();
         chk("stream_accepted", 32'(idx), 32'd6);
         chk("stream_ready_low", 32'(nlow), 32'd3);
         chk("stream_count", 32'(st_log.size()), 32'd6);
         for (int i = 0; i < st_log.size() && i < 6; i++) begin
            chk($sformatf("stream_wr%0d", i), {st_log[i].pc, st_log[i].dest, st_log[i].data},
                {1'b0, 4'(i + 1), 32'h50 + 32'(i)});
            if (i > 0)
               chk($sformatf("stream_gap%0d", i), 32'(st_log[i].cyc - st_log[i-1].cyc), 32'd2);
         end
      end

      // Reset while r4 sits in SETUP with r10 still queued
      do_reset();
      alu_valid = 1'b1; alu_dest = 4'd4; alu_data = 32'h44;
      tick();
      alu_dest = 4'd10; alu_data = 32'hAA;
      tick();
      drop_inputs();
      chk("rst_mid_setup", {write, dest_add, data_write}, {1'b0, 4'd4, 32'h44});
      reset = 1'b1;
      tick();
      chk("rst_mid_outs", outs(), '0);
      chk("rst_mid_ready", {alu_ready, mem_ready}, 2'b00);
      reset = 1'b0;
      st_log.delete();
      repeat (8) tick();
      chk("rst_mid_no_strobe", 32'(st_log.size()), 32'd0);

`ifdef WB_BYPASS_EN
      // Bypass lookup: MEM queue beats ALU queue beats in-flight
      do_reset();
      lkp_add = 4'd7;
      alu_valid = 1'b1; alu_dest = 4'd7; alu_data = 32'hA;
      mem_valid = 1'b1; mem_dest = 4'd7; mem_data = 32'hB;
      tick();
      drop_inputs();
      chk("bp_mem_youngest", {lkp_hit, lkp_data}, {1'b1, 32'hB});
      lkp_add = 4'd9;
      #1;
      chk("bp_miss", {lkp_hit, lkp_data}, {1'b0, 32'h0});
      lkp_add = 4'd7;
      tick();
      chk("bp_alu_over_inflight", {lkp_hit, lkp_data}, {1'b1, 32'hA});
      tick();
      tick();
      chk("bp_inflight", {lkp_hit, lkp_data}, {1'b1, 32'hA});
      lkp_add = PC;
      #1;
      chk("bp_pc_miss", {lkp_hit, lkp_data}, {1'b0, 32'h0});
      repeat (4) tick();
`endif

      // Randomized traffic scored against the acceptance log
      begin
         int tag;
         int w;
         int total;
         int last_cyc[2];
         ent_t qa[$];
         ent_t qm[$];
         logic ok;
         do_reset();
         acc_alu.delete();
         acc_mem.delete();
         st_log.delete();
         tag = 0;
         for (int c = 0; c < 400; c++) begin
            alu_valid = 1'($urandom_range(0, 1));
            alu_dest  = ($urandom_range(0, 3) == 0) ? PC : 4'($urandom_range(0, 14));
            alu_data  = {8'hA0, 24'(tag)};
            mem_valid = 1'($urandom_range(0, 1));
            mem_dest  = ($urandom_range(0, 3) == 0) ? PC : 4'($urandom_range(0, 14));
            mem_data  = {8'hB0, 24'(tag)};
            tag++;
            tick();
         end
         drop_inputs();
         total = acc_alu.size() + acc_mem.size();
         w = 0;
         while (st_log.size() < total && w < 400) begin
            tick();
            w++;
         end
         repeat (4) tick();
         chk("rand_drain", 32'(st_log.size()), 32'(total));
         qa = acc_alu;
         qm = acc_mem;
         last_cyc[0] = -10;
         last_cyc[1] = -10;
         foreach (st_log[i]) begin
            ok = 1'b0;
            if (qa.size() > 0 && qa[0].data == st_log[i].data && qa[0].dest == st_log[i].dest
                && ((qa[0].dest == PC) == st_log[i].pc)) begin
               void'(qa.pop_front());
               ok = 1'b1;
            end else if (qm.size() > 0 && qm[0].data == st_log[i].data && qm[0].dest == st_log[i].dest
                && ((qm[0].dest == PC) == st_log[i].pc)) begin
               void'(qm.pop_front());
               ok = 1'b1;
            end
            chk($sformatf("rand_order pc=%0d dest=%0d data=%0h", st_log[i].pc, st_log[i].dest,
                st_log[i].data), ok, 1'b1);
            chk("rand_spacing", (st_log[i].cyc - last_cyc[st_log[i].pc]) >= 2, 1'b1);
            last_cyc[st_log[i].pc] = st_log[i].cyc;
         end
         chk("rand_lost", 32'(qa.size() + qm.size()), 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
